fetch_unit: RTL

//  Instruction-fetch stage of the RV32I core, directly upstream of decode/control.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit_pc_reg.sv | 17 +
 rtl/fetch_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared RV32I opcodes, NOP word and fetch FSM state encodings.
package fetch_unit_pkg;
  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] OPCODE_LW     = 7'b0000011;
  localparam logic [6:0] OPCODE_SW     = 7'b0100011;
  localparam logic [6:0] OPCODE_BEQ    = 7'b1100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [31:0] NOP_INSTR    = {25'h0000000, OPCODE_OP_IMM};
  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_VALID = 2'b01,
    S_DROP  = 2'b10
  } fetch_state_e;
  function automatic logic [6:0] opcode_of(input logic [31:0] w);
    return w[6:0];
  endfunction
endpackage

// File: rtl/fetch_unit_pc_reg.sv
// fetch_unit_pc_reg: fetch PC register with load/increment enables; loads are forced word-aligned.
module fetch_unit_pc_reg #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load,
  input  logic [XLEN-1:0] load_val,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) pc <= RESET_PC & ALIGN_MASK;
    else pc <= load ? (load_val & ALIGN_MASK) : inc ? pc + XLEN'(4) : pc;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch over a req/ack imem port with branch redirect and stall.
// FETCH_PERF_CNT_EN adds perf_fetch_cnt_o counting instructions handed downstream.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt_o
`endif
);
  fetch_state_e state, state_n;
  logic [XLEN-1:0] fetch_pc, pend_tgt;
  logic pc_load, pc_inc, latch, clr_valid, pend_we;
  fetch_unit_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (pc_load),
    .load_val (branch_i ? branch_target_i : pend_tgt),
    .inc      (pc_inc),
    .pc       (fetch_pc)
  );
  assign imem_req_o  = !rst_i && (state == S_FETCH || state == S_DROP);
  assign imem_addr_o = fetch_pc;
  assign opcode_o    = opcode_of(instr_o);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= S_FETCH;
    else state <= state_n;
  // A branch always wins: in S_DROP the outstanding request must still drain before redirecting.
  always_comb begin
    state_n   = state;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    latch     = 1'b0;
    clr_valid = 1'b0;
    pend_we   = 1'b0;
    case (state)
      S_FETCH:
        if (branch_i) begin
          pc_load = imem_ack_i;
          pend_we = !imem_ack_i;
          state_n = imem_ack_i ? S_FETCH : S_DROP;
        end else if (imem_ack_i) begin
          latch   = 1'b1;
          pc_inc  = 1'b1;
          state_n = S_VALID;
        end
      S_VALID:
        if (branch_i || !stall_i) begin
          clr_valid = 1'b1;
          pc_load   = branch_i;
          state_n   = S_FETCH;
        end
      S_DROP: begin
        pend_we = branch_i;
        pc_load = imem_ack_i;
        state_n = imem_ack_i ? S_FETCH : S_DROP;
      end
      default: state_n = S_FETCH;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      instr_valid_o <= 1'b0;
      instr_o       <= NOP_INSTR;
      pc_o          <= RESET_PC;
      pend_tgt      <= RESET_PC;
    end else begin
      instr_valid_o <= latch ? 1'b1 : clr_valid ? 1'b0 : instr_valid_o;
      instr_o       <= latch ? imem_rdata_i : instr_o;
      pc_o          <= latch ? fetch_pc : pc_o;
      pend_tgt      <= pend_we ? (branch_target_i & ~XLEN'(3)) : pend_tgt;
    end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) perf_fetch_cnt_o <= '0;
    else if (instr_valid_o && !stall_i && !branch_i) perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
`endif
endmodule
